// File: rtl/dma_regfile_ex_if.sv
// Command and bus handshake bundle for dma_regfile_ex.
// master = command/bus-response source, slave = the register file.
interface dma_regfile_ex_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_type;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [ADDR_W-1:0] cmd_rd;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_wvalid;
    logic              bus_wready;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;
    logic              bus_rready;

    modport master (
        output cmd_valid, cmd_op, cmd_type, cmd_rs1, cmd_rs2, cmd_rd,
        output bus_wready, bus_rdata, bus_rvalid,
        input  cmd_ready, bus_wdata, bus_wvalid, bus_rready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_type, cmd_rs1, cmd_rs2, cmd_rd,
        input  bus_wready, bus_rdata, bus_rvalid,
        output cmd_ready, bus_wdata, bus_wvalid, bus_rready
    );
endinterface

// File: rtl/dma_regfile_ex.sv
// Register file with store/load bus channels and single-cycle add/sub.
// Optional macro DMA_RF_BYPASS_EN forwards same-cycle writes to the read ports.
module dma_regfile_ex #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dma_regfile_ex_if.slave   io,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ovf
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

    state_t                           state;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    logic [ADDR_W-1:0]                rd_q;
    logic                             accept;
    logic                             type_ok;
    logic                             arith_go;
    logic [DATA_W-1:0]                op_a;
    logic [DATA_W-1:0]                op_b;
    logic [DATA_W-1:0]                arith_res;
    logic                             arith_ovf;
    logic                             wr_en;
    logic [ADDR_W-1:0]                wr_addr;
    logic [DATA_W-1:0]                wr_data;

    assign io.cmd_ready = (state == IDLE);
    assign accept       = io.cmd_valid && io.cmd_ready;
    assign type_ok      = (io.cmd_type == 2'b00) || (io.cmd_type == 2'b11);
    assign arith_go     = accept && type_ok && io.cmd_op[1];
    assign op_a         = regs[io.cmd_rs1];
    assign op_b         = regs[io.cmd_rs2];
    assign arith_res    = io.cmd_op[0] ? (op_a - op_b) : (op_a + op_b);

    // Overflow: effective operand signs agree but the result sign differs.
    assign arith_ovf = io.cmd_op[0]
        ? ((op_a[DATA_W-1] != op_b[DATA_W-1]) && (arith_res[DATA_W-1] != op_a[DATA_W-1]))
        : ((op_a[DATA_W-1] == op_b[DATA_W-1]) && (arith_res[DATA_W-1] != op_a[DATA_W-1]));

    // Arithmetic accept and load completion are exclusive (IDLE vs LOAD).
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = io.cmd_rd;
        wr_data = arith_res;
        if (arith_go) begin
            wr_en = 1'b1;
        end else if (state == LOAD && io.bus_rvalid) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = io.bus_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= DATA_W'(k);
            state         <= IDLE;
            rd_q          <= '0;
            io.bus_wdata  <= '0;
            io.bus_wvalid <= 1'b0;
            io.bus_rready <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            ovf <= arith_go && arith_ovf;
            if (wr_en) regs[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (accept && type_ok && io.cmd_op == OP_STORE) begin
                        io.bus_wdata  <= op_a;
                        io.bus_wvalid <= 1'b1;
                        state         <= STORE;
                    end else if (accept && type_ok && io.cmd_op == OP_LOAD) begin
                        rd_q          <= io.cmd_rd;
                        io.bus_rready <= 1'b1;
                        state         <= LOAD;
                    end
                end
                STORE: begin
                    if (io.bus_wready) begin
                        io.bus_wvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                LOAD: begin
                    if (io.bus_rvalid) begin
                        io.bus_rready <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMA_RF_BYPASS_EN
    assign rdata_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    assign rdata_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
`else
    assign rdata_a = regs[rd_addr_a];
    assign rdata_b = regs[rd_addr_b];
`endif
endmodule
